// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register with load-use hazard detection and a writeback
// bypass into the captured register operands.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   id_*              : instruction fields from the decode stage
//   flush             : squash the instruction entering EX (taken branch)
//   wb_en/wb_rd/wb_data : writeback bus shared with the register file
//   stall             : combinational load-use hold request to IF/ID
//   ex_*              : registered instruction fields presented to EX
//
// id_ctrl[0] is reg_write and id_ctrl[1] is mem_read; all other control bits
// pass through untouched.
// ---------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,

  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_op1,
  input  logic [31:0] id_op2,
  input  logic [15:0] id_ctrl,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,

  input  logic        flush,

  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,

  output logic        stall,

  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [15:0] ex_ctrl
);

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q,    ex_pc_d;
  logic [31:0] ex_imm_q,   ex_imm_d;
  logic [4:0]  ex_rs1_q,   ex_rs1_d;
  logic [4:0]  ex_rs2_q,   ex_rs2_d;
  logic [4:0]  ex_rd_q,    ex_rd_d;
  logic [31:0] ex_op1_q,   ex_op1_d;
  logic [31:0] ex_op2_q,   ex_op2_d;
  logic [15:0] ex_ctrl_q,  ex_ctrl_d;

  logic hazard;
  logic bubble;
  logic fwd_op1;
  logic fwd_op2;

  // Only the older instruction already sitting in EX is compared; a load
  // there whose destination is read by the decoding instruction must wait.
  assign hazard = ex_valid_q & ex_ctrl_q[1] & (ex_rd_q != 5'd0) & id_valid &
                  ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
                   (id_uses_rs2 & (id_rs2 == ex_rd_q)));

  // A flush kills the dependent instruction anyway, so no hold is needed.
  assign stall  = hazard & ~flush;
  assign bubble = flush | stall | ~id_valid;

  // The register file is written on the same edge this stage captures, so
  // its read data can be one write stale; take the writeback value instead.
  // The bypass ignores id_uses_* because an unused operand is harmless.
  assign fwd_op1 = wb_en & (wb_rd != 5'd0) & (wb_rd == id_rs1);
  assign fwd_op2 = wb_en & (wb_rd != 5'd0) & (wb_rd == id_rs2);

  always_comb begin
    ex_valid_d = id_valid;
    ex_pc_d    = id_pc;
    ex_imm_d   = id_imm;
    ex_rs1_d   = id_rs1;
    ex_rs2_d   = id_rs2;
    ex_rd_d    = id_rd;
    ex_op1_d   = fwd_op1 ? wb_data : id_op1;
    ex_op2_d   = fwd_op2 ? wb_data : id_op2;
    ex_ctrl_d  = id_ctrl;
    // A bubble only needs valid, ctrl and rd cleared; the data fields are
    // ignored downstream so they are left to follow ID.
    if (bubble) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = 16'd0;
      ex_rd_d    = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= 32'd0;
      ex_imm_q   <= 32'd0;
      ex_rs1_q   <= 5'd0;
      ex_rs2_q   <= 5'd0;
      ex_rd_q    <= 5'd0;
      ex_op1_q   <= 32'd0;
      ex_op2_q   <= 32'd0;
      ex_ctrl_q  <= 16'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_pc    = ex_pc_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rs1   = ex_rs1_q;
  assign ex_rs2   = ex_rs2_q;
  assign ex_rd    = ex_rd_q;
  assign ex_op1   = ex_op1_q;
  assign ex_op2   = ex_op2_q;
  assign ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed testbench for id_ex_stage: pass-through, load-use stall, flush
// priority, writeback bypass, x0 handling, id_valid bubbles and asynchronous
// reset. Expected values are written out by hand for each vector.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_op1;
  logic [31:0] id_op2;
  logic [15:0] id_ctrl;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [15:0] ex_ctrl;

  int total = 0;
  int bad   = 0;

  id_ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_imm      (id_imm),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_op1      (id_op1),
    .id_op2      (id_op2),
    .id_ctrl     (id_ctrl),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_op1      (ex_op1),
    .ex_op2      (ex_op2),
    .ex_ctrl     (ex_ctrl)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one decode-stage instruction
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [15:0] ctrl, input logic u1,
                               input logic u2);
    id_valid    = v;
    id_pc       = pc;
    id_imm      = imm;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_op1      = op1;
    id_op2      = op2;
    id_ctrl     = ctrl;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Safety net so the run always ends
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    wb_en   = 1'b0;
    wb_rd   = 5'd0;
    wb_data = 32'd0;
    applyStimulus(1'b1, 32'h100, 32'h40, 5'd1, 5'd2, 5'd2, 32'd5, 32'd7,
                  16'h0001, 1'b1, 1'b1);

    // Reset state, held across a clock edge
    step();
    checkOutput("rst_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("rst_pc",    ex_pc, 32'd0);
    checkOutput("rst_op1",   ex_op1, 32'd0);
    checkOutput("rst_ctrl",  {16'd0, ex_ctrl}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);

    // Release reset between edges; first edge captures
    #2 rst = 1'b1;
    step();
    checkOutput("pass_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("pass_pc",    ex_pc, 32'h100);
    checkOutput("pass_imm",   ex_imm, 32'h40);
    checkOutput("pass_op1",   ex_op1, 32'd5);
    checkOutput("pass_op2",   ex_op2, 32'd7);
    checkOutput("pass_ctrl",  {16'd0, ex_ctrl}, 32'h0001);
    checkOutput("pass_rd",    {27'd0, ex_rd}, 32'd2);
    checkOutput("pass_rs1",   {27'd0, ex_rs1}, 32'd1);
    checkOutput("pass_rs2",   {27'd0, ex_rs2}, 32'd2);

    // Load rd=3 enters EX; older instruction is not a load, so no stall
    applyStimulus(1'b1, 32'h104, 32'h8, 5'd1, 5'd0, 5'd3, 32'hA, 32'd0,
                  16'h0003, 1'b1, 1'b0);
    #1 checkOutput("lw_nostall", {31'd0, stall}, 32'd0);
    step();
    checkOutput("lw_rd",   {27'd0, ex_rd}, 32'd3);
    checkOutput("lw_ctrl", {16'd0, ex_ctrl}, 32'h0003);

    // Dependent on rs2=3: load-use stall, then a single bubble
    applyStimulus(1'b1, 32'h108, 32'h0, 5'd5, 5'd3, 5'd6, 32'h50, 32'h30,
                  16'h0001, 1'b1, 1'b1);
    #1 checkOutput("lu_stall", {31'd0, stall}, 32'd1);
    step();
    checkOutput("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu_bub_ctrl",  {16'd0, ex_ctrl}, 32'd0);
    checkOutput("lu_bub_rd",    {27'd0, ex_rd}, 32'd0);
    checkOutput("lu_bub_stall", {31'd0, stall}, 32'd0);
    step();
    checkOutput("lu_replay_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("lu_replay_pc",    ex_pc, 32'h108);
    checkOutput("lu_replay_rd",    {27'd0, ex_rd}, 32'd6);

    // Another load rd=3, then a reader that does not use rs2
    applyStimulus(1'b1, 32'h10C, 32'h0, 5'd1, 5'd0, 5'd3, 32'd0, 32'd0,
                  16'h0003, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 32'h110, 32'h0, 5'd0, 5'd3, 5'd7, 32'd0, 32'd0,
                  16'h0001, 1'b1, 1'b0);
    #1 checkOutput("unused_rs2_stall", {31'd0, stall}, 32'd0);

    // Hazard present but flush wins
    id_uses_rs2 = 1'b1;
    #1 checkOutput("pre_flush_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1 checkOutput("flush_stall", {31'd0, stall}, 32'd0);
    step();
    checkOutput("flush_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_ctrl",  {16'd0, ex_ctrl}, 32'd0);
    checkOutput("flush_rd",    {27'd0, ex_rd}, 32'd0);
    flush = 1'b0;

    // Writeback bypass into both operands (uses_* cleared on purpose)
    applyStimulus(1'b1, 32'h200, 32'h0, 5'd4, 5'd4, 5'd8, 32'h11, 32'h22,
                  16'h0001, 1'b0, 1'b0);
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEAD;
    step();
    checkOutput("byp_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("byp_op1",   ex_op1, 32'hDEAD);
    checkOutput("byp_op2",   ex_op2, 32'hDEAD);
    wb_rd = 5'd0;
    step();
    checkOutput("byp_x0_op1", ex_op1, 32'h11);
    checkOutput("byp_x0_op2", ex_op2, 32'h22);
    wb_en = 1'b0; wb_rd = 5'd4;
    step();
    checkOutput("byp_off_op1", ex_op1, 32'h11);
    checkOutput("byp_off_op2", ex_op2, 32'h22);
    // Only rs2 matches: operands stay independent
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hBEEF;
    id_rs2 = 5'd9;
    step();
    checkOutput("byp_ind_op1", ex_op1, 32'h11);
    checkOutput("byp_ind_op2", ex_op2, 32'hBEEF);
    wb_en = 1'b0;

    // Load to x0 never stalls; wb to x0 never bypasses
    applyStimulus(1'b1, 32'h300, 32'h0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0,
                  16'h0003, 1'b1, 1'b1);
    step();
    applyStimulus(1'b1, 32'h304, 32'h0, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0,
                  16'h0001, 1'b1, 1'b1);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1 checkOutput("x0_stall", {31'd0, stall}, 32'd0);
    step();
    checkOutput("x0_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("x0_op1",   ex_op1, 32'd0);
    checkOutput("x0_op2",   ex_op2, 32'd0);
    wb_en = 1'b0;

    // Invalid ID slot becomes a bubble
    applyStimulus(1'b0, 32'h308, 32'h0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2,
                  16'h00F3, 1'b1, 1'b1);
    step();
    checkOutput("inv_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("inv_ctrl",  {16'd0, ex_ctrl}, 32'd0);

    // Async reset mid-cycle with a pending load-use hazard
    applyStimulus(1'b1, 32'h400, 32'h4, 5'd1, 5'd2, 5'd3, 32'h77, 32'h88,
                  16'h0003, 1'b1, 1'b1);
    step();
    checkOutput("ar_pre_valid", {31'd0, ex_valid}, 32'd1);
    applyStimulus(1'b1, 32'h500, 32'h0, 5'd3, 5'd0, 5'd4, 32'h99, 32'd0,
                  16'h0001, 1'b1, 1'b0);
    #1 checkOutput("ar_pre_stall", {31'd0, stall}, 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("ar_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("ar_pc",    ex_pc, 32'd0);
    checkOutput("ar_op1",   ex_op1, 32'd0);
    checkOutput("ar_ctrl",  {16'd0, ex_ctrl}, 32'd0);
    checkOutput("ar_rd",    {27'd0, ex_rd}, 32'd0);
    checkOutput("ar_stall", {31'd0, stall}, 32'd0);
    #1 rst = 1'b1;
    step();
    checkOutput("ar_cap_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("ar_cap_pc",    ex_pc, 32'h500);
    checkOutput("ar_cap_op1",   ex_op1, 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1; rising-edge clock.
REQ-002 SHALL have port rst, input, 1; reset, asynchronous, active-low.
REQ-003 SHALL have inputs id_valid (1), id_pc (32), id_imm (32), id_rs1/id_rs2/id_rd (5 each), id_op1/id_op2 (32 each, register-file read data), id_ctrl (16), id_uses_rs1/id_uses_rs2 (1 each).
REQ-004 SHALL have input flush, 1; squash the instruction entering EX (branch taken in EX).
REQ-005 SHALL have inputs wb_en (1), wb_rd (5), wb_data (32); the same writeback bus that drives the register file.
REQ-006 SHALL have output stall, 1; combinational load-use hold request to IF/ID.
REQ-007 SHALL have registered outputs ex_valid (1), ex_pc (32), ex_imm (32), ex_rs1/ex_rs2/ex_rd (5 each), ex_op1/ex_op2 (32 each), ex_ctrl (16).
REQ-008 SHALL treat id_ctrl[0] as reg_write and id_ctrl[1] as mem_read; other bits pass through unmodified.

Function
REQ-009 SHALL register all ID fields to the ex_* outputs with exactly one cycle of latency on each rising clk edge.
REQ-010 SHALL compute hazard = ex_valid & ex_ctrl[1] & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-011 SHALL drive stall = hazard & ~flush, combinationally, in the same cycle.
REQ-012 SHALL, when flush=1, load a bubble: ex_valid=0, ex_ctrl=0, ex_rd=0; the other ex_* fields are don't-care.
REQ-013 SHALL, when stall=1 and flush=0, load a bubble identical to REQ-012; the ID instruction is re-presented by upstream in the next cycle.
REQ-014 SHALL give flush priority over hazard; both active -> bubble, stall=0.
REQ-015 SHALL, when id_valid=0, load a bubble (ex_valid=0, ex_ctrl=0).
REQ-016 SHALL forward writeback into the captured operands: if wb_en & (wb_rd != 0) & (wb_rd == id_rs1), ex_op1 <= wb_data, else ex_op1 <= id_op1; the same rule applies to op2 with id_rs2.
REQ-017 SHALL never forward for wb_rd = 0; x0 reads remain whatever id_op1/id_op2 present (0).
REQ-018 SHALL apply the bypass in REQ-016 regardless of id_uses_rs1/id_uses_rs2.
REQ-019 SHALL keep ex_op1 and ex_op2 independent; a single wb_rd matching both rs1 and rs2 updates both.
REQ-020 SHALL not evaluate hazard against the incoming instruction itself; only the ex_* (older) instruction is compared.
REQ-021 SHALL produce no multi-cycle stall from one load; after one bubble, ex_valid=0 and hazard clears.

Reset
REQ-022 SHALL, on rst=0, asynchronously clear every ex_* output to 0 (ex_valid=0), independent of clk.
REQ-023 SHALL drive stall=0 while rst=0, because ex_valid=0.
REQ-024 SHALL, after rst deasserts, capture normally on the first rising clk edge.
REQ-025 SHALL discard an in-flight instruction when reset asserts mid-operation; there is no replay.

Verification
REQ-026 Pass-through: id_valid=1, id_pc=0x100, id_op1=5, id_op2=7, id_ctrl=0x0001, no wb -> next cycle ex_valid=1, ex_pc=0x100, ex_op1=5, ex_op2=7, ex_ctrl=0x0001.
REQ-027 Load-use: ex holds lw with ex_rd=3 and ex_ctrl[1]=1; ID has id_rs2=3, id_uses_rs2=1 -> stall=1 in that cycle; next cycle ex_valid=0, ex_ctrl=0, stall=0.
REQ-028 WB bypass: id_rs1=4, id_op1=0x11, wb_en=1, wb_rd=4, wb_data=0xDEAD -> ex_op1=0xDEAD; repeating with wb_rd=0 or wb_en=0 -> ex_op1=0x11.
REQ-029 Flush with hazard: hazard conditions of REQ-027 plus flush=1 -> stall=0; next cycle ex_valid=0, ex_ctrl=0, ex_rd=0.
REQ-030 x0 cases: lw with ex_rd=0 followed by a use of rs1=0 -> stall=0; wb_rd=0 with wb_data=0xFFFF_FFFF -> no bypass.
REQ-031 Async reset: assert rst=0 between clk edges while ex_valid=1 -> ex_* outputs are 0 immediately and stall=0; after release, the next edge captures ID data.
